// File: rtl/seq_shift_right.sv
// seq_shift_right: multi-cycle srl/sra unit for the multicycle MIPS datapath.
// Shifts up to STEP bits per clock under a start/done handshake. The unit
// latches its operands when a request is accepted, then walks the shift
// amount down to zero. The last step may be shorter than STEP.
// Optional feature macro: SHIFT_LEFT_EN. When it is defined, the unit gets a
// dir port and also performs a logical left shift (sll/sllv) when dir=1.
module seq_shift_right #(
  parameter  int WIDTH = 32,
  parameter  int STEP  = 1,
  localparam int SW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [SW-1:0]    shamt,
  input  logic             arith,
`ifdef SHIFT_LEFT_EN
  input  logic             dir,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] y
);

  typedef enum logic {IDLE, SHIFT} state_t;

  // STEP never exceeds WIDTH-1, so it always fits in the shamt width.
  localparam logic [SW-1:0] STEP_W = SW'(STEP);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [SW-1:0]      rem_q, rem_d;
  logic               fill_q, fill_d;
  logic [WIDTH-1:0]   y_q, y_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
`ifdef SHIFT_LEFT_EN
  logic               dir_q, dir_d;
`endif

  logic [SW-1:0]      k;
  logic signed [WIDTH:0] ext_s;
  logic [WIDTH-1:0]   shifted;

  // Step datapath: the shift distance for this cycle is min(STEP, rem). The
  // operand is extended by one fill bit so that one arithmetic shift covers
  // both sra (sign fill) and srl (zero fill).
  always_comb begin
    k       = (rem_q < STEP_W) ? rem_q : STEP_W;
    ext_s   = $signed({fill_q & acc_q[WIDTH-1], acc_q});
    shifted = WIDTH'(ext_s >>> k);
`ifdef SHIFT_LEFT_EN
    // Left shifts always zero-fill. The latched arith bit is not used here.
    if (dir_q) shifted = acc_q << k;
`endif
  end

  // Control: accept a request in IDLE and step the shift in SHIFT. A zero
  // shift amount completes on the accepting edge and never enters SHIFT.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    fill_d  = fill_q;
    y_d     = y_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
`ifdef SHIFT_LEFT_EN
    dir_d   = dir_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          acc_d  = a;
          rem_d  = shamt;
          fill_d = arith;
`ifdef SHIFT_LEFT_EN
          dir_d  = dir;
`endif
          if (shamt == '0) begin
            y_d    = a;
            done_d = 1'b1;
          end else begin
            state_d = SHIFT;
            busy_d  = 1'b1;
          end
        end
      end
      SHIFT: begin
        // Any start seen here is ignored; the operands stay as latched.
        acc_d = shifted;
        rem_d = rem_q - k;
        if (rem_q == k) begin
          y_d     = shifted;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers. An asynchronous reset aborts any operation
  // in flight, and no done is produced for it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      rem_q   <= '0;
      fill_q  <= 1'b0;
      y_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SHIFT_LEFT_EN
      dir_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
      fill_q  <= fill_d;
      y_q     <= y_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef SHIFT_LEFT_EN
      dir_q   <= dir_d;
`endif
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign y    = y_q;

endmodule
